// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================
// cp0_pkg : CP0 register map, ExcCodes, field masks, resets
// Rev 1.0
// ============================================================
package cp0_pkg;

  // Register address encoded as {reg number, select}
  localparam logic [7:0] c_a_badvaddr = {5'd8,  3'd0};
  localparam logic [7:0] c_a_count    = {5'd9,  3'd0};
  localparam logic [7:0] c_a_compare  = {5'd11, 3'd0};
  localparam logic [7:0] c_a_status   = {5'd12, 3'd0};
  localparam logic [7:0] c_a_cause    = {5'd13, 3'd0};
  localparam logic [7:0] c_a_epc      = {5'd14, 3'd0};
  localparam logic [7:0] c_a_prid     = {5'd15, 3'd0};
  localparam logic [7:0] c_a_ebase    = {5'd15, 3'd1};

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_MOD  = 5'h01,
    EXC_TLBL = 5'h02,
    EXC_TLBS = 5'h03,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OV   = 5'h0C,
    EXC_ERET = 5'h1F
  } exc_code_e;

  localparam int c_st_exl = 1;

  localparam logic [31:0] c_status_wmask = 32'h0040_FF03;
  localparam logic [31:0] c_cause_wmask  = 32'h0000_0300;
  localparam logic [31:0] c_status_reset = 32'h0040_0000;

  // Only address-related exceptions capture the faulting address
  function automatic logic sets_badvaddr(input logic [4:0] code);
    return (code == EXC_MOD)  || (code == EXC_TLBL) || (code == EXC_TLBS) ||
           (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_regfile_if.sv
`default_nettype none
// ============================================================
// cp0_regfile_if : MFC0/MTC0 bus and exception-unit link
// Rev 1.0
// ============================================================
interface cp0_regfile_if;
  logic        we;
  logic [4:0]  waddr;
  logic [2:0]  wsel;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [2:0]  rsel;
  logic [31:0] rdata;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] bad_vaddr_i;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] ebase_o;

  modport master (
    output we, waddr, wsel, wdata, raddr, rsel,
    output exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, bad_vaddr_i,
    input  rdata, status_o, cause_o, epc_o, ebase_o
  );

  modport slave (
    input  we, waddr, wsel, wdata, raddr, rsel,
    input  exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i, bad_vaddr_i,
    output rdata, status_o, cause_o, epc_o, ebase_o
  );
endinterface
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================
// cp0_timer : half-rate Count, Compare and timer interrupt TI
// Rev 1.0
// ============================================================
module cp0_timer (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        count_we,
  input  wire logic        compare_we,
  input  wire logic [31:0] wdata,
  output logic [31:0]      count_o,
  output logic [31:0]      compare_o,
  output logic             ti_o
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_toggle;
  logic        r_ti;
  logic [31:0] w_count_inc;

  assign w_count_inc = r_count + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count   <= '0;
      r_compare <= '0;
      r_toggle  <= 1'b0;
      r_ti      <= 1'b0;
    end else begin
      if (count_we) begin
        r_count  <= wdata;
        r_toggle <= 1'b0;
      end else begin
        r_toggle <= ~r_toggle;
        if (r_toggle) r_count <= w_count_inc;
      end
      // A Compare write acknowledges the interrupt even if a match lands now
      if (compare_we) begin
        r_compare <= wdata;
        r_ti      <= 1'b0;
      end else if (!count_we && r_toggle && (w_count_inc == r_compare)) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign count_o   = r_count;
  assign compare_o = r_compare;
  assign ti_o      = r_ti;

endmodule
`default_nettype wire

// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================
// cp0_regfile : CP0 architectural state, MFC0/MTC0, timer IRQ
// Rev 1.0
// ============================================================
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE  = 32'h0001_8000,
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  cp0_regfile_if.slave    bus,
  input  wire logic [5:0] hw_int_i,
  output logic            timer_int_o
);

  logic [31:0] r_status, r_epc, r_badvaddr;
  logic        r_bd;
  logic [4:0]  r_exccode;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_hw;
  logic [17:0] r_ebase;

  logic [31:0] w_count, w_compare, w_cause, w_ebase, w_rdata;
  logic [7:0]  w_waddr, w_raddr;
  logic        w_ti, w_exc, w_eret, w_mtc0;

  assign w_waddr = {bus.waddr, bus.wsel};
  assign w_raddr = {bus.raddr, bus.rsel};
  assign w_exc   = bus.exc_valid_i && (bus.exc_code_i != EXC_ERET);
  assign w_eret  = bus.exc_valid_i && (bus.exc_code_i == EXC_ERET);
  // A committing exception/ERET flushes the MTC0 in the pipe behind it
  assign w_mtc0  = bus.we && !bus.exc_valid_i;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (w_mtc0 && (w_waddr == c_a_count)),
    .compare_we (w_mtc0 && (w_waddr == c_a_compare)),
    .wdata      (bus.wdata),
    .count_o    (w_count),
    .compare_o  (w_compare),
    .ti_o       (w_ti)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_status   <= c_status_reset;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_bd       <= 1'b0;
      r_exccode  <= '0;
      r_ip_sw    <= '0;
      r_hw       <= '0;
      r_ebase    <= EBASE_RESET[29:12];
    end else begin
      r_hw <= hw_int_i;
      if (w_exc) begin
        if (!r_status[c_st_exl]) begin
          r_epc <= bus.exc_bd_i ? (bus.exc_pc_i - 32'd4) : bus.exc_pc_i;
          r_bd  <= bus.exc_bd_i;
        end
        r_status[c_st_exl] <= 1'b1;
        r_exccode          <= bus.exc_code_i;
        if (sets_badvaddr(bus.exc_code_i)) r_badvaddr <= bus.bad_vaddr_i;
      end else if (w_eret) begin
        r_status[c_st_exl] <= 1'b0;
      end else if (w_mtc0) begin
        if (w_waddr == c_a_status) r_status <= bus.wdata & c_status_wmask;
        if (w_waddr == c_a_cause)  r_ip_sw  <= bus.wdata[9:8];
        if (w_waddr == c_a_epc)    r_epc    <= bus.wdata;
        if (w_waddr == c_a_ebase)  r_ebase  <= bus.wdata[29:12];
      end
    end
  end

  assign w_cause = {r_bd, w_ti, 14'd0, r_hw[5] | w_ti, r_hw[4:0], r_ip_sw,
                    1'b0, r_exccode, 2'b00};
  assign w_ebase = {2'b10, r_ebase, 12'd0};

  always_comb begin
    w_rdata = '0;
    case (w_raddr)
      c_a_badvaddr: w_rdata = r_badvaddr;
      c_a_count:    w_rdata = w_count;
      c_a_compare:  w_rdata = w_compare;
      c_a_status:   w_rdata = r_status;
      c_a_cause:    w_rdata = w_cause;
      c_a_epc:      w_rdata = r_epc;
      c_a_prid:     w_rdata = PRID_VALUE;
      c_a_ebase:    w_rdata = w_ebase;
      default:      w_rdata = '0;
    endcase
    // Same-cycle MTC0 to the read register forwards its masked value
    if (bus.we && (w_waddr == w_raddr)) begin
      case (w_waddr)
        c_a_status:  w_rdata = bus.wdata & c_status_wmask;
        c_a_cause:   w_rdata = (w_cause & ~c_cause_wmask) | (bus.wdata & c_cause_wmask);
        c_a_epc,
        c_a_count,
        c_a_compare: w_rdata = bus.wdata;
        c_a_ebase:   w_rdata = {2'b10, bus.wdata[29:12], 12'd0};
        default:     ;
      endcase
    end
  end

  assign bus.rdata    = w_rdata;
  assign bus.status_o = r_status;
  assign bus.cause_o  = w_cause;
  assign bus.epc_o    = r_epc;
  assign bus.ebase_o  = w_ebase;
  assign timer_int_o  = w_ti;

endmodule
`default_nettype wire

// File: doc/cp0_regfile.md
# cp0_regfile

- Holds the architectural CP0 state: Status, Cause, EPC, BadVAddr, Count, Compare, PRId and EBase.
- Receives committed exception and ERET events from the memory-stage exception unit and records them.
- Feeds Status, Cause, EPC and EBase back to that exception unit.
- Serves MFC0/MTC0 and generates the timer interrupt.

## Interface
Parameters:
- PRID_VALUE, 32'h0001_8000, read-only PRId value (sel 0).
- EBASE_RESET, 32'h8000_0000, EBase reset value.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- we  in  1  MTC0 write strobe.
- waddr / wsel  in  5 / 3  MTC0 register number / select.
- wdata  in  32  MTC0 data.
- raddr / rsel  in  5 / 3  MFC0 register number / select.
- rdata  out  32  MFC0 data, combinational.
- exc_valid_i  in  1  exception or ERET committed this cycle (the exception unit's clear).
- exc_code_i  in  5  ExcCode, or the EXC_ERET pseudo-code.
- exc_pc_i  in  32  PC of the faulting instruction.
- exc_bd_i  in  1  faulting instruction is in a delay slot.
- bad_vaddr_i  in  32  faulting address; for fetch AdEL the pipeline drives the PC here.
- hw_int_i  in  6  external interrupt lines, level-sensitive.
- status_o / cause_o / epc_o / ebase_o  out  32  registered copies of the registers.
- timer_int_o  out  1  equals Cause.TI.

## Operation
Register map (reg, sel):
- BadVAddr (8,0): read-only to software.
- Count (9,0).
- Compare (11,0).
- Status (12,0): writable bits BEV[22], IM[15:8], EXL[1], IE[0]; all others read 0.
- Cause (13,0): writable bits IP[1:0] only. Read-only fields: BD[31], TI[30], IP[7:2], ExcCode[6:2].
- EPC (14,0): fully writable.
- PRId (15,0): read-only.
- EBase (15,1): writable bits [29:12]; bit 31 reads 1; all others read 0.
- Any unmapped (reg, sel) reads 0; writes to it are ignored.

Reset values (rst==0 at a clock edge):
- Status = 32'h0040_0000.
- Cause, EPC, BadVAddr, Count, Compare all 0.
- EBase = EBASE_RESET.
- Count half-rate toggle = 0.
- All outputs follow these values the cycle after the edge.

Exception commit (exc_valid_i=1 and exc_code_i≠EXC_ERET):
- If Status.EXL=0: EPC←exc_bd_i ? exc_pc_i−4 : exc_pc_i; Cause.BD←exc_bd_i.
- If Status.EXL=1: EPC and BD are held (nested exception).
- Always: Status.EXL←1; Cause.ExcCode←exc_code_i.
- BadVAddr←bad_vaddr_i only for AdEL, AdES, TLBL, TLBS and Mod.

ERET (exc_valid_i=1, exc_code_i=EXC_ERET): Status.EXL←0; nothing else changes.

Interrupt pending bits:
- Cause.IP[6:2]←hw_int_i[4:0] every cycle.
- Cause.IP[7]←hw_int_i[5] | Cause.TI.

Timer:
- Count increments once every 2 cycles and wraps from FFFF_FFFF to 0.
- TI is set on the edge where Count increments to a value equal to Compare.
- TI holds until an MTC0 to Compare clears it.

## Timing
- All state updates occur on the rising edge; status_o/cause_o/epc_o reflect an event one cycle later.
- rdata is combinational. If we=1 and (waddr,wsel)==(raddr,rsel), rdata returns the post-mask written value (bypass).
- Simultaneous exception and MTC0: the exception wins and the MTC0 is dropped, since its instruction is flushed.
- MTC0 Count and an increment in the same cycle: the written value wins and the toggle resets to 0.
- MTC0 Compare and a timer match in the same cycle: the write wins and TI ends at 0.
- MTC0 Cause updates IP[1:0] only.
- rst is synchronous and overrides every other event in the same cycle, including a mid-flight exception.

## Structure
- Package cp0_pkg holds:
  - register numbers and selects;
  - ExcCode constants: Int 00, Mod 01, TLBL 02, TLBS 03, AdEL 04, AdES 05, Sys 08, Bp 09, RI 0A, Ov 0C, EXC_ERET 1F;
  - Status/Cause bit positions and write masks;
  - reset constants.
- Sub-module cp0_timer holds Count, Compare, the half-rate toggle and TI. It exposes write ports and ti_o.

## Test plan
- Reset: drive rst=0 for 1 cycle → status_o=0040_0000, cause_o=0, epc_o=0, ebase_o=8000_0000, PRId reads 0001_8000.
- Plain exception: exc_code=0C (Ov), exc_pc=BFC0_0100, exc_bd=0, EXL=0 → next cycle epc_o=BFC0_0100, Status.EXL=1, ExcCode=0C, BadVAddr unchanged.
- Delay slot, then nested exception:
  - AdES with exc_bd=1, pc=8000_1004, bad_vaddr=0000_0003 → EPC=8000_1000, BD=1, BadVAddr=0000_0003.
  - Then Sys while EXL=1 → EPC stays 8000_1000, ExcCode=08.
- ERET: exc_code=1F with EXL=1 → EXL=0; EPC and ExcCode unchanged.
- Timer:
  - MTC0 Compare=5, Count=0 → TI and IP[7] rise on the edge where Count becomes 5 (cycle 10).
  - MTC0 Compare=5 again → TI=0 the next cycle.
  - Count=FFFF_FFFF wraps to 0 after 2 cycles.
- Write masking and priority:
  - MTC0 Status=FFFF_FFFF → reads 0040_FF03.
  - MTC0 Cause=FFFF_FFFF → only IP[1:0] set.
  - MTC0 EPC coinciding with an exception commit → EPC takes the exception value.
